// File: rtl/hazard_pkg.sv
// Shared latency constants and types for the hazard scoreboard.
package hazard_pkg;

  localparam int unsigned LAT_W = 3;

  typedef logic [LAT_W-1:0] lat_t;

  localparam lat_t LAT_ALU  = LAT_W'(1);
  localparam lat_t LAT_LOAD = LAT_W'(2);
  localparam lat_t LAT_MUL  = LAT_W'(3);
  localparam lat_t LAT_DIV  = LAT_W'(7);

endpackage

// File: rtl/hazard_reg_counter.sv
// Per-register countdown of cycles until the pending write becomes forwardable.
module hazard_reg_counter
  import hazard_pkg::*;
#(
  parameter int unsigned LAT_W = hazard_pkg::LAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] cnt,
  output logic             busy
);

  logic [LAT_W-1:0] cnt_next;

  // A new issue reloads the counter; otherwise count down to zero unless frozen.
  always_comb begin
    cnt_next = cnt;
    if (!freeze) begin
      if (load) begin
        cnt_next = load_val;
      end else if (cnt != '0) begin
        cnt_next = cnt - LAT_W'(1);
      end
    end
  end

  // Counter and busy flag registered together so busy always matches cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      busy <= (cnt_next != '0);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: tracks in-flight write latencies and raises
// RAW/WAW stalls for the instruction sitting in ID.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned LAT_W      = hazard_pkg::LAT_W,
  parameter int unsigned BR_THRESH  = 1,
  parameter int unsigned ALU_THRESH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic                id_uses_rs1,
  input  logic                id_uses_rs2,
  input  logic                id_is_branch,
  input  logic                id_reg_write,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic [LAT_W-1:0]    id_lat,
  input  logic                freeze,
  input  logic                flush,
  output logic                stall,
  output logic                stall_raw,
  output logic                stall_waw,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [31:0]         stall_count
);

  // Full index space so any REG_AW-wide index reads a defined value.
  localparam int unsigned DEPTH = 1 << REG_AW;

  logic [LAT_W-1:0] cnt [DEPTH];
  logic             busy_int [DEPTH];
  logic             issue;
  logic             tracked_write;
  logic             hazard_1;
  logic             hazard_2;
  logic [31:0]      thresh;

  assign cnt[0]      = '0;
  assign busy_int[0] = 1'b0;

  // One countdown per architectural register; indices past NUM_REGS read zero.
  for (genvar r = 1; r < DEPTH; r++) begin : g_reg
    if (r < NUM_REGS) begin : g_cnt
      logic load;
      assign load = issue && tracked_write && (id_rd == REG_AW'(r));
      hazard_reg_counter #(
        .LAT_W (LAT_W)
      ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .freeze   (freeze),
        .load     (load),
        .load_val (id_lat),
        .cnt      (cnt[r]),
        .busy     (busy_int[r])
      );
    end else begin : g_none
      assign cnt[r]      = '0;
      assign busy_int[r] = 1'b0;
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_busy
    assign busy_vec[r] = busy_int[r];
  end

  // Hazard detection is purely combinational so ID sees the stall this cycle.
  always_comb begin
    thresh        = id_is_branch ? 32'(BR_THRESH) : 32'(ALU_THRESH);
    tracked_write = id_reg_write && (id_rd != '0) && (id_lat != '0);
    hazard_1      = id_uses_rs1 && (id_rs1 != '0) && (32'(cnt[id_rs1]) >= thresh);
    hazard_2      = id_uses_rs2 && (id_rs2 != '0) && (32'(cnt[id_rs2]) >= thresh);
    stall_raw     = id_valid && (hazard_1 || hazard_2);
    stall_waw     = id_valid && id_reg_write && (id_rd != '0) && (cnt[id_rd] > id_lat);
    stall         = (stall_raw || stall_waw) && !flush;
    issue         = id_valid && !stall && !freeze && !flush;
  end

  // Saturating count of cycles the pipeline actually spent stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && !freeze && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2, id_is_branch, id_reg_write;
  logic [2:0]  id_lat;
  logic        freeze, flush;
  logic        stall, stall_raw, stall_waw;
  logic [31:0] busy_vec;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;

  // Model state: remaining cycles per register and the stall total.
  int          mcnt [32];
  int unsigned mcount = 0;

  hazard_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .id_is_branch (id_is_branch),
    .id_reg_write (id_reg_write),
    .id_rd        (id_rd),
    .id_lat       (id_lat),
    .freeze       (freeze),
    .flush        (flush),
    .stall        (stall),
    .stall_raw    (stall_raw),
    .stall_waw    (stall_waw),
    .busy_vec     (busy_vec),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 32; i++) mcnt[i] = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference rules: a source hazards when its register still needs at least
  // the threshold cycles; a write hazards when the older write outlives it.
  task automatic m_eval(output bit raw, output bit waw, output bit st);
    int  thr;
    bit  h1, h2;
    thr = id_is_branch ? 1 : 2;
    h1  = id_uses_rs1 && id_rs1 != 0 && mcnt[id_rs1] >= thr;
    h2  = id_uses_rs2 && id_rs2 != 0 && mcnt[id_rs2] >= thr;
    raw = id_valid && (h1 || h2);
    waw = id_valid && id_reg_write && id_rd != 0 && mcnt[id_rd] > int'(id_lat);
    st  = (raw || waw) && !flush;
  endtask

  // Model advance on each clock edge.
  always @(posedge clk or negedge rst_n) begin
    bit raw, waw, st;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mcnt[i] <= 0;
      mcount <= 0;
    end else begin
      m_eval(raw, waw, st);
      if (!freeze) begin
        for (int i = 1; i < 32; i++) if (mcnt[i] > 0) mcnt[i] <= mcnt[i] - 1;
        if (id_valid && !st && !flush && id_reg_write && id_rd != 0 && id_lat != 0)
          mcnt[id_rd] <= int'(id_lat);
        if (st && mcount != 32'hFFFF_FFFF) mcount <= mcount + 1;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    bit raw, waw, st;
    logic [31:0] ebusy;
    m_eval(raw, waw, st);
    ebusy = '0;
    for (int i = 1; i < 32; i++) ebusy[i] = (mcnt[i] != 0);
    chk("model_stall", 32'(stall), 32'(st));
    chk("model_raw", 32'(stall_raw), 32'(raw));
    chk("model_waw", 32'(stall_waw), 32'(waw));
    chk("model_busy", busy_vec, ebusy);
    chk("model_count", stall_count, mcount);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                       input bit br, input bit rw, input int rd, input int lat,
                       input bit fz, input bit fl);
    id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_is_branch = br;
    id_reg_write = rw; id_rd = 5'(rd); id_lat = 3'(lat);
    freeze = fz; flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Count consecutive stall cycles of the instruction held in ID (bounded).
  task automatic count_stalls(input int limit, output int n);
    n = 0;
    #1;
    while (stall && n < limit) begin
      n++;
      tick();
      #1;
    end
  endtask

  initial begin
    int n;
    idle();
    rst_n = 1'b0;
    #2;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_busy", busy_vec, 32'd0);
    chk("reset_count", stall_count, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Load x5 then dependent add: one stall cycle.
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 1, 5, 2, 0, 0);
    tick();
    drive(1, 5, 0, 1, 0, 0, 1, 8, 1, 0, 0);
    #1;
    chk("load_use_stall", 32'(stall), 32'd1);
    chk("load_use_raw", 32'(stall_raw), 32'd1);
    chk("load_use_waw", 32'(stall_waw), 32'd0);
    tick();
    #1;
    chk("load_use_release", 32'(stall), 32'd0);
    chk("load_use_count", stall_count, 32'd1);
    tick();
    idle();
    #1;
    chk("add_busy_x8", 32'(busy_vec[8]), 32'd1);

    // Branch after load: two stalls; branch after ALU op: one stall.
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 1, 5, 2, 0, 0);
    tick();
    drive(1, 5, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    count_stalls(10, n);
    chk("branch_load_stalls", 32'(n), 32'd2);
    tick();
    drive(1, 0, 0, 0, 0, 0, 1, 6, 1, 0, 0);
    tick();
    drive(1, 0, 6, 0, 1, 1, 0, 0, 0, 0, 0);
    count_stalls(10, n);
    chk("branch_alu_stalls", 32'(n), 32'd1);
    chk("branch_count", stall_count, 32'd3);
    tick();

    // Div x7 then short write to x7: WAW stall until cnt <= 1.
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 1, 7, 1, 0, 0);
    #1;
    chk("waw_flag", 32'(stall_waw), 32'd1);
    chk("waw_no_raw", 32'(stall_raw), 32'd0);
    count_stalls(12, n);
    chk("waw_stalls", 32'(n), 32'd6);
    chk("waw_count", stall_count, 32'd6);
    tick();

    // Freeze holds state and the stall counter.
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 1, 5, 2, 0, 0);
    tick();
    drive(1, 5, 0, 1, 0, 0, 1, 9, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("freeze_stall", 32'(stall), 32'd1);
      chk("freeze_busy5", 32'(busy_vec[5]), 32'd1);
      tick();
    end
    chk("freeze_count", stall_count, 32'd0);
    freeze = 1'b0;
    #1;
    chk("unfreeze_stall", 32'(stall), 32'd1);
    tick();
    #1;
    chk("resume_release", 32'(stall), 32'd0);
    chk("resume_count", stall_count, 32'd1);
    tick();
    idle();

    // Flush suppresses stall and issue; x0 is never tracked.
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 1, 5, 2, 0, 0);
    tick();
    drive(1, 5, 0, 1, 0, 0, 1, 9, 1, 0, 1);
    #1;
    chk("flush_stall", 32'(stall), 32'd0);
    chk("flush_raw", 32'(stall_raw), 32'd1);
    tick();
    idle();
    #1;
    chk("flush_no_load", 32'(busy_vec[9]), 32'd0);
    chk("flush_keeps_x5", 32'(busy_vec[5]), 32'd1);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 7, 0, 0);
    tick();
    idle();
    #1;
    chk("x0_untracked", busy_vec, 32'd0);

    // Reset mid-countdown clears everything at once.
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0);
    tick();
    drive(1, 7, 0, 1, 0, 0, 1, 10, 1, 0, 0);
    tick();
    tick();
    chk("pre_reset_stall", 32'(stall), 32'd1);
    chk("pre_reset_count", stall_count, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", busy_vec, 32'd0);
    chk("midreset_stall", 32'(stall), 32'd0);
    chk("midreset_count", stall_count, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_reset_stall", 32'(stall), 32'd0);
    tick();
    idle();

    // Randomized traffic over a small register window.
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 9) < 8), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
            $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
      if (c == 1 || c % 5 == 0) id_rs1 = id_rd;
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 32, number of architectural registers; register 0 is never tracked.
REQ-002 Parameter REG_AW, default 5, register-index width; SHALL satisfy 2**REG_AW >= NUM_REGS.
REQ-003 Parameter LAT_W, default 3, latency-field width; maximum tracked latency is 2**LAT_W-1.
REQ-004 Parameter BR_THRESH, default 1; a branch consumer stalls when its source count is >= BR_THRESH.
REQ-005 Parameter ALU_THRESH, default 2; a non-branch consumer stalls when its source count is >= ALU_THRESH.
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 rst_n  input  1  reset, asynchronous and active-low.
REQ-008 id_valid  input  1  valid instruction in ID.
REQ-009 id_rs1, id_rs2  input  REG_AW each  ID source indices.
REQ-010 id_uses_rs1, id_uses_rs2  input  1 each  source is actually read.
REQ-011 id_is_branch  input  1  ID instruction resolves in ID.
REQ-012 id_reg_write, id_rd  input  1, REG_AW  ID instruction writes id_rd.
REQ-013 id_lat  input  LAT_W  cycles after issue until id_rd becomes forwardable (1 ALU, 2 load, N multi-cycle); 0 means untracked.
REQ-014 freeze  input  1  whole pipeline held (e.g. memory wait).
REQ-015 flush  input  1  ID instruction squashed this cycle.
REQ-016 stall  output  1  hold IF/ID and insert a bubble into EX.
REQ-017 stall_raw, stall_waw  output  1 each  stall cause flags.
REQ-018 busy_vec  output  NUM_REGS  bit r set when cnt[r] != 0.
REQ-019 stall_count  output  32  saturating count of stall cycles.

Function
REQ-020 Per-register state is cnt[r], LAT_W bits; cnt[0] SHALL read as 0 at all times.
REQ-021 issue = id_valid && !stall && !freeze && !flush.
REQ-022 On issue with id_reg_write, id_rd != 0 and id_lat != 0, cnt[id_rd] SHALL load id_lat on the next edge; the load takes priority over that register's decrement.
REQ-023 On every edge with !freeze, each nonzero cnt not being loaded SHALL decrement by 1; under freeze, all cnt SHALL hold.
REQ-024 Per source: hazard_x = id_uses_rsx && rsx != 0 && cnt[rsx] >= (id_is_branch ? BR_THRESH : ALU_THRESH).
REQ-025 stall_raw = id_valid && (hazard_1 || hazard_2).
REQ-026 stall_waw = id_valid && id_reg_write && id_rd != 0 && cnt[id_rd] > id_lat, so a younger short-latency write never completes before an older long one.
REQ-027 stall = (stall_raw || stall_waw) && !flush; all three outputs are combinational from current state and inputs, with zero latency.
REQ-028 stall is independent of freeze; during freeze it reflects the frozen state.
REQ-029 Flush SHALL NOT modify any cnt, because older in-flight writes remain valid.
REQ-030 stall_count SHALL increment by 1 on each edge with stall && !freeze, and saturate at 0xFFFFFFFF.
REQ-031 id_rs1 == id_rs2 SHALL be evaluated as a single hazard with no double effect.

Reset
REQ-032 While rst_n is low, all cnt and stall_count SHALL be 0; therefore busy_vec=0, and stall=0, stall_raw=0 and stall_waw=0.
REQ-033 Reset asserted mid-countdown SHALL clear all state immediately; after release, no stale hazard SHALL exist.

Structure
REQ-034 A shared package hazard_pkg SHALL hold LAT_W and the latency constants LAT_ALU=1, LAT_LOAD=2, LAT_MUL=3 and LAT_DIV=7.
REQ-035 One sub-module, hazard_reg_counter (load/decrement/hold countdown, busy output), SHALL be instantiated for registers 1..NUM_REGS-1 via generate.

Verification
REQ-036 Issue a load x5 (lat 2), then an add reading x5 next cycle -> stall=1 for exactly 1 cycle, stall_raw=1, stall_count=1.
REQ-037 Issue a load x5 (lat 2), then a branch reading x5 -> stall for 2 cycles; issue an ALU op x6 (lat 1), then a branch on x6 -> 1 stall cycle.
REQ-038 Issue a div x7 (lat 7), then an add writing x7 (lat 1) -> stall_waw=1 until cnt[7] <= 1, which is 6 stall cycles.
REQ-039 Load x5 in flight with freeze held 3 cycles -> busy_vec[5] stays 1 and cnt holds; stall_count does not advance; the countdown resumes after freeze drops.
REQ-040 Dependent add on x5 with flush=1 in the same cycle -> stall=0, no cnt load; a write to x0 with lat 7 -> busy_vec stays 0.
REQ-041 Assert rst_n low mid-countdown of a lat-7 op -> busy_vec=0, stall=0 immediately; stall_count returns to 0.
